// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
// Holds the frame width and the receive state encodings.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Generic two-flop synchronizer for an asynchronous single-bit input.
// RESET_VAL lets the output come out of reset at the input's idle level.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, finds the start edge, samples each bit
// mid-period and reports good bytes (data_valid) or bad stop bits (frame_err).
//
//   state | meaning
//   IDLE  | waiting for a falling edge on the synchronized line
//   START | half a bit period in; confirms the start bit is still low
//   DATA  | sampling 8 data bits, LSB first, one per bit period
//   STOP  | sampling the stop bit; high = good byte, low = framing error
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      data_valid,
  output logic                      frame_err,
  output logic                      busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = $clog2(UART_DATA_BITS);
  localparam int HALF = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);

  logic                      rx_s;
  logic                      rx_s_d;
  rx_state_t                 state, state_nx;
  logic [CW-1:0]             cnt, cnt_nx;
  logic [IW-1:0]             idx, idx_nx;
  logic [UART_DATA_BITS-1:0] shreg, shreg_nx;
  logic [UART_DATA_BITS-1:0] data_nx;
  logic                      valid_nx;
  logic                      err_nx;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s_d     <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_s_d     <= rx_s;
      state      <= state_nx;
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      shreg      <= shreg_nx;
      data       <= data_nx;
      data_valid <= valid_nx;
      frame_err  <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    idx_nx   = idx;
    shreg_nx = shreg;
    data_nx  = data;
    valid_nx = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        // Edge-triggered so a line stuck low (break) never restarts reception.
        if (!rx_s && rx_s_d) state_nx = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nx   = '0;
          idx_nx   = '0;
          state_nx = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_nx   = '0;
          shreg_nx = {rx_s, shreg[UART_DATA_BITS-1:1]};
          idx_nx   = idx + 1'b1;
          if (idx == IDX_LAST) state_nx = STOP;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_nx   = '0;
          state_nx = IDLE;
          if (rx_s) begin
            data_nx  = shreg;
            valid_nx = 1'b1;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames,
// scored against an expected-event queue built from the frame timing rules.
module tb_uart_rx;

  localparam int CPB = 8;
  localparam int LATENCY = 2 + CPB / 2 + 9 * CPB;

  typedef struct {
    bit         is_err;
    logic [7:0] b;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [7:0] model_data = 8'h00;
  bit   prev_pulse = 0;
  bit   busy_seen = 0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every pulse must match the oldest expected event exactly.
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid || frame_err) begin
        checks++;
        assert (!(data_valid && frame_err)) else begin
          errors++; $error("FAIL both_pulses cyc=%0d valid=%b err=%b", cyc, data_valid, frame_err);
        end
        checks++;
        assert (prev_pulse === 1'b0) else begin
          errors++; $error("FAIL consecutive_pulse cyc=%0d observed=1 expected=0", cyc);
        end
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++; $error("FAIL unexpected_pulse cyc=%0d valid=%b err=%b data=%02h", cyc, data_valid, frame_err, data);
        end
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          checks++;
          assert (cyc === mon_e.cyc) else begin
            errors++; $error("FAIL pulse_time observed=%0d expected=%0d", cyc, mon_e.cyc);
          end
          checks++;
          assert (frame_err === logic'(mon_e.is_err)) else begin
            errors++; $error("FAIL pulse_kind observed_err=%b expected_err=%b", frame_err, mon_e.is_err);
          end
          if (!mon_e.is_err) model_data = mon_e.b;
        end
      end else if (exp_q.size() != 0) begin
        checks++;
        assert (cyc < exp_q[0].cyc) else begin
          errors++; $error("FAIL missed_pulse cyc=%0d expected_at=%0d", cyc, exp_q[0].cyc);
          void'(exp_q.pop_front());
        end
      end
      checks++;
      assert (data === model_data) else begin
        errors++; $error("FAIL data cyc=%0d observed=%02h expected=%02h", cyc, data, model_data);
      end
      prev_pulse = data_valid || frame_err;
      if (busy) busy_seen = 1;
    end else begin
      prev_pulse = 0;
    end
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just before rx falls: the first sync flop captures it on the next edge.
  task automatic expect_frame(input logic [7:0] b, input logic stop);
    exp_t e;
    e.is_err = !stop;
    e.b      = b;
    e.cyc    = cyc + 1 + LATENCY;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    expect_frame(b, stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;
    int         g;

    rx = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; assert (data === 8'h00) else begin errors++; $error("FAIL reset_data observed=%02h expected=00", data); end
    checks++; assert (data_valid === 1'b0) else begin errors++; $error("FAIL reset_valid observed=%b expected=0", data_valid); end
    checks++; assert (frame_err === 1'b0) else begin errors++; $error("FAIL reset_err observed=%b expected=0", frame_err); end
    checks++; assert (busy === 1'b0) else begin errors++; $error("FAIL reset_busy observed=%b expected=0", busy); end
    rst_n = 1'b1;
    idle(10);
    checks++; assert (busy === 1'b0) else begin errors++; $error("FAIL idle_busy observed=%b expected=0", busy); end

    send_frame(8'hA5, 1'b1);
    idle(5);
    checks++; assert (data === 8'hA5) else begin errors++; $error("FAIL frame_a5 observed=%02h expected=a5", data); end

    send_frame(8'h3C, 1'b0);
    idle(3);
    checks++; assert (data === 8'hA5) else begin errors++; $error("FAIL err_keeps_data observed=%02h expected=a5", data); end
    checks++; assert (busy === 1'b0) else begin errors++; $error("FAIL err_busy observed=%b expected=0", busy); end

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(5);
    checks++; assert (data === 8'hFF) else begin errors++; $error("FAIL back_to_back observed=%02h expected=ff", data); end

    busy_seen = 0;
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle(20);
    checks++; assert (busy_seen === 1'b1) else begin errors++; $error("FAIL glitch_busy_seen observed=%b expected=1", busy_seen); end
    checks++; assert (busy === 1'b0) else begin errors++; $error("FAIL glitch_busy_after observed=%b expected=0", busy); end

    expect_frame(8'h00, 1'b0);
    rx = 1'b0;
    repeat (40 * CPB) @(posedge clk);
    #1;
    checks++; assert (busy === 1'b0) else begin errors++; $error("FAIL break_busy observed=%b expected=0", busy); end
    idle(16);
    send_frame(8'h81, 1'b1);
    idle(5);
    checks++; assert (data === 8'h81) else begin errors++; $error("FAIL after_break observed=%02h expected=81", data); end

    // Truncated 0x5A: start, bits 0..2, then reset part-way through bit 3.
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    rx = 1'b1;
    model_data = 8'h00;
    #1;
    checks++; assert (data === 8'h00) else begin errors++; $error("FAIL midreset_data observed=%02h expected=00", data); end
    checks++; assert (busy === 1'b0) else begin errors++; $error("FAIL midreset_busy observed=%b expected=0", busy); end
    checks++; assert (data_valid === 1'b0) else begin errors++; $error("FAIL midreset_valid observed=%b expected=0", data_valid); end
    checks++; assert (frame_err === 1'b0) else begin errors++; $error("FAIL midreset_err observed=%b expected=0", frame_err); end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(20);
    checks++; assert (busy === 1'b0) else begin errors++; $error("FAIL post_reset_busy observed=%b expected=0", busy); end
    send_frame(8'h5A, 1'b1);
    idle(5);
    checks++; assert (data === 8'h5A) else begin errors++; $error("FAIL frame_5a observed=%02h expected=5a", data); end

    for (int n = 0; n < 24; n++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rb, rs);
      g = $urandom_range(0, 3);
      if (!rs && g == 0) g = 1;
      if (g != 0) idle(g);
    end
    idle(2);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++; $error("FAIL drain pending=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART frame receiver: recovers 8N1 frames (one start bit, 8 data bits LSB first, one stop bit) from an asynchronous serial line. It is the receive-side counterpart of the existing UART transmitter and sits between the board RX pin and byte-oriented consumer logic. The block presents each good byte with a one-cycle valid pulse and flags malformed frames.

## Interface
- CLKS_PER_BIT, default 16: clk cycles per bit period; legal range 4..65535; integer.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- data  output  8  last correctly received byte; held until the next good frame.
- data_valid  output  1  one-cycle pulse; data is updated in the same cycle.
- frame_err  output  1  one-cycle pulse; stop bit sampled low.
- busy  output  1  high whenever the state is not IDLE.

## Operation
- rx passes through a 2-flop synchronizer to give rx_s. rx_s_d is a one-cycle delayed copy of rx_s.
- The state register is 2 bits: IDLE, START, DATA, STOP.
- The bit counter cnt runs 0..CLKS_PER_BIT-1. The bit index idx runs 0..7. HALF = CLKS_PER_BIT/2, using integer division.
- IDLE: when rx_s==0 and rx_s_d==1 (a falling edge), go to START with cnt=0. A line that is held low never triggers a start.
- START: at cnt==HALF-1, sample rx_s.
  - If the sample is 0, the start bit is valid: go to DATA with cnt=0 and idx=0.
  - If the sample is 1, it was a glitch: return to IDLE with no output.
- DATA: at cnt==CLKS_PER_BIT-1, sample rx_s into the shift register (shift right, new bit in at the MSB) and reset cnt to 0.
  - Increment idx after each sample.
  - After the sample at idx==7, go to STOP.
- STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
  - If the sample is 1: data <= shift register and pulse data_valid.
  - If the sample is 0: pulse frame_err and leave data unchanged.
  - In both cases go to IDLE.
- Each sample point lands mid-bit because START consumes a half bit period.
- Reset values:
  - data=8'h00, data_valid=0, frame_err=0, busy=0.
  - State IDLE, cnt=0, idx=0.
  - Both synchronizer flops and rx_s_d reset to 1, the idle level, so no false start occurs out of reset.
- Reset mid-frame: everything returns to reset values immediately. The partial frame is discarded with no pulse. After reset deasserts, reception restarts only on the next falling edge.
- data_valid and frame_err are mutually exclusive and never high for two consecutive cycles.

## Timing
- Let T0 be the clk edge at which the first synchronizer flop captures rx low.
  - rx_s is low from T0+1.
  - The START state is entered at T0+2.
- The stop sample occurs at T0+2+HALF+9*CLKS_PER_BIT-1.
  - data_valid or frame_err is high for exactly the cycle after the stop sample: T0+2+HALF+9*CLKS_PER_BIT.
  - busy drops in that same cycle.
- A new start edge may be detected in the first IDLE cycle, so back-to-back frames with no idle time are received correctly.
- Accepted baud mismatch is ±(HALF-1)/(10*CLKS_PER_BIT) relative to the transmitter.
- No combinational path from rx to any output.

## Structure
- Shared package uart_pkg, also used by uart_tx, holds:
  - UART_DATA_BITS=8.
  - The state encodings IDLE/START/DATA/STOP as localparams.
- Sub-module uart_rx_sync: a generic 2-flop synchronizer with a reset value parameter (here 1). It is reused for other async inputs.
- cnt width is $clog2(CLKS_PER_BIT).

## Test plan
All scenarios use CLKS_PER_BIT=8 and drive rx with ideal 8-cycle bits.
- Frame 0xA5 → data_valid pulses once exactly 78 cycles after T0 (2+4+72); data=8'hA5; frame_err stays 0.
- Back-to-back frames 0x00 then 0xFF, with the second start bit immediately after the first stop bit → two data_valid pulses 80 cycles apart; data=00 then FF.
- rx low for 2 cycles, then high → busy pulses briefly; no data_valid, no frame_err; data unchanged.
- Frame 0x3C with the stop bit driven low → frame_err pulses once; data keeps its prior value 8'hA5; busy is 0 afterwards.
- rx held low for 40 bit periods (a break) → exactly one frame_err and no further activity until rx returns high; a following frame 0x81 is received correctly.
- rst_n asserted low in the middle of the data bits of 0x5A → all outputs go to reset values asynchronously; after release, no pulse for the truncated frame; the next full frame 0x5A gives data_valid with data=8'h5A.
